// File: rtl/cic_adpcm_wrapper.sv
// PDM-to-ADPCM front end: 3rd-order CIC decimator (R=64) into 16-bit PCM,
// followed by a single-cycle IMA/DVI ADPCM encoder paced by slow_clk strobes.
module cic_adpcm_wrapper #(
  parameter int DEC   = 64,
  parameter int PCM_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              slow_clk,
  input  logic              block_enable,
  input  logic              pdm_in,
  output logic              outValid,
  output logic signed [3:0] encPcm
);

  localparam int ACC_W = 19;
  localparam int CNT_W = $clog2(DEC);

  localparam logic [14:0] STEP_TBL [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442,
    11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794,
    32767
  };

  // A full-scale window gives +/-2^18, which aliases to the same 19-bit code;
  // only an all-equal input window can reach it, so any in-window bit resolves the sign.
  function automatic logic signed [PCM_W-1:0] to_pcm(input logic signed [ACC_W-1:0] c,
                                                     input logic pos);
    logic signed [ACC_W-1:0] s;
    s = c >>> 3;
    if (c == {1'b1, {(ACC_W-1){1'b0}}} && pos)
      return {1'b0, {(PCM_W-1){1'b1}}};
    if (s[ACC_W-1:PCM_W-1] == '0 || s[ACC_W-1:PCM_W-1] == '1)
      return s[PCM_W-1:0];
    return s[ACC_W-1] ? {1'b1, {(PCM_W-1){1'b0}}} : {1'b0, {(PCM_W-1){1'b1}}};
  endfunction

  function automatic logic signed [PCM_W-1:0] sat_pred(input logic signed [PCM_W+1:0] v);
    if (v[PCM_W+1:PCM_W-1] == '0 || v[PCM_W+1:PCM_W-1] == '1)
      return v[PCM_W-1:0];
    return v[PCM_W+1] ? {1'b1, {(PCM_W-1){1'b0}}} : {1'b0, {(PCM_W-1){1'b1}}};
  endfunction

  function automatic logic signed [7:0] idx_adj(input logic [2:0] c);
    case (c)
      3'd4:    return 8'sd2;
      3'd5:    return 8'sd4;
      3'd6:    return 8'sd6;
      3'd7:    return 8'sd8;
      default: return -8'sd1;
    endcase
  endfunction

  function automatic logic [6:0] clamp_idx(input logic signed [7:0] v);
    if (v < 0)   return 7'd0;
    if (v > 88)  return 7'd88;
    return v[6:0];
  endfunction

  logic signed [ACC_W-1:0] x_p0, int1_p0, int2_p0, int3_p0;
  logic signed [ACC_W-1:0] dly1_p1, dly2_p1, dly3_p1, c1, c2, c3;
  logic [CNT_W-1:0]        cnt_p0;
  logic [2:0]              pdm_sr_p0;
  logic signed [PCM_W-1:0] pcm_p1, pred_p2;
  logic                    pending_p1, slow_d, strobe, sample_p0;
  logic [6:0]              idx_p2;

  logic [14:0]             step;
  logic [PCM_W:0]          diff, mag, rem, step_w, vp;
  logic                    sgn;
  logic [2:0]              code;
  logic signed [PCM_W+1:0] pred_sum;

  assign x_p0      = pdm_in ? ACC_W'(1) : '1;
  assign c1        = int3_p0 - dly1_p1;
  assign c2        = c1 - dly2_p1;
  assign c3        = c2 - dly3_p1;
  assign sample_p0 = (cnt_p0 == CNT_W'(DEC - 1));
  assign strobe    = slow_clk & ~slow_d;

  // p0: integrators and decimation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1_p0 <= '0; int2_p0 <= '0; int3_p0 <= '0;
      dly1_p1 <= '0; dly2_p1 <= '0; dly3_p1 <= '0;
      cnt_p0 <= '0; pdm_sr_p0 <= '0; pcm_p1 <= '0;
    end else if (!block_enable) begin
      int1_p0 <= '0; int2_p0 <= '0; int3_p0 <= '0;
      dly1_p1 <= '0; dly2_p1 <= '0; dly3_p1 <= '0;
      cnt_p0 <= '0; pdm_sr_p0 <= '0;
    end else begin
      int1_p0   <= int1_p0 + x_p0;
      int2_p0   <= int2_p0 + int1_p0;
      int3_p0   <= int3_p0 + int2_p0;
      pdm_sr_p0 <= {pdm_sr_p0[1:0], pdm_in};
      cnt_p0    <= sample_p0 ? '0 : cnt_p0 + 1'b1;
      // p1: comb section, evaluated only at the decimation instant
      if (sample_p0) begin
        dly1_p1 <= int3_p0;
        dly2_p1 <= c1;
        dly3_p1 <= c2;
        pcm_p1  <= to_pcm(c3, pdm_sr_p0[2]);
      end
    end
  end

  always_comb begin
    step     = STEP_TBL[idx_p2];
    step_w   = {2'b0, step};
    diff     = {pcm_p1[PCM_W-1], pcm_p1} - {pred_p2[PCM_W-1], pred_p2};
    sgn      = diff[PCM_W];
    mag      = sgn ? (~diff + 1'b1) : diff;
    rem      = mag;
    vp       = step_w >> 3;
    code     = 3'd0;
    if (rem >= step_w) begin
      code[2] = 1'b1; rem = rem - step_w; vp = vp + step_w;
    end
    if (rem >= (step_w >> 1)) begin
      code[1] = 1'b1; rem = rem - (step_w >> 1); vp = vp + (step_w >> 1);
    end
    if (rem >= (step_w >> 2)) begin
      code[0] = 1'b1; vp = vp + (step_w >> 2);
    end
    pred_sum = sgn ? ({{2{pred_p2[PCM_W-1]}}, pred_p2} - {1'b0, vp})
                   : ({{2{pred_p2[PCM_W-1]}}, pred_p2} + {1'b0, vp});
  end

  // p2: strobe-paced ADPCM encoder state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_d <= 1'b0; pending_p1 <= 1'b0; outValid <= 1'b0;
      encPcm <= '0; pred_p2 <= '0; idx_p2 <= '0;
    end else begin
      slow_d <= slow_clk;
      if (!block_enable) begin
        pending_p1 <= 1'b0;
        outValid   <= 1'b0;
      end else begin
        outValid <= strobe & pending_p1;
        if (strobe && pending_p1) begin
          encPcm  <= {sgn, code};
          pred_p2 <= sat_pred(pred_sum);
          idx_p2  <= clamp_idx($signed({1'b0, idx_p2}) + idx_adj(code));
        end
        if (sample_p0)   pending_p1 <= 1'b1;
        else if (strobe) pending_p1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_adpcm_wrapper.sv
// Randomized bench for cic_adpcm_wrapper against a convolution-based CIC
// reference and an arithmetic IMA ADPCM encoder model.
module tb_cic_adpcm_wrapper;
  logic       clk = 1'b0, rst_n = 1'b0, slow_clk = 1'b0, block_enable = 1'b0, pdm_in = 1'b0;
  logic       outValid;
  logic [3:0] encPcm;

  cic_adpcm_wrapper #(.DEC(64), .PCM_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .block_enable(block_enable),
    .pdm_in(pdm_in), .outValid(outValid), .encPcm(encPcm)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  int STEP [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442,
    11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794,
    32767
  };
  int IDX_ADJ [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  // Reference model: CIC = box64 * box64 * box64 impulse response applied to +/-1 samples
  int         h [0:189];
  int         hist [0:19999];
  int         e_cnt, m_pcm, m_pred, m_idx, cyc;
  bit         m_pending, m_valid, slow_prev, first_watch;
  logic [3:0] m_code;

  function automatic int pcm_at(input int t);
    longint y = 0;
    int     p;
    for (int k = 0; k < 190; k++)
      if (t - 3 - k >= 0) y += longint'(h[k]) * hist[t - 3 - k];
    p = int'(y >>> 3);
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return p;
  endfunction

  task automatic encode(input int pcm);
    int diff, d, step, vp, c, s;
    diff = pcm - m_pred;
    s    = (diff < 0);
    d    = s ? -diff : diff;
    step = STEP[m_idx];
    vp   = step / 8;
    c    = 0;
    if (d >= step)     begin c += 4; d -= step;     vp += step;     end
    if (d >= step / 2) begin c += 2; d -= step / 2; vp += step / 2; end
    if (d >= step / 4) begin c += 1;                vp += step / 4; end
    m_pred = s ? m_pred - vp : m_pred + vp;
    if (m_pred > 32767)  m_pred = 32767;
    if (m_pred < -32768) m_pred = -32768;
    m_idx += IDX_ADJ[c];
    if (m_idx < 0)  m_idx = 0;
    if (m_idx > 88) m_idx = 88;
    m_code = 4'(s * 8 + c);
  endtask

  task automatic model_reset();
    e_cnt = 0; m_pcm = 0; m_pred = 0; m_idx = 0; m_code = 4'd0;
    m_pending = 0; m_valid = 0; slow_prev = 0;
  endtask

  task automatic model_step(input bit pdm, input bit slow, input bit en);
    bit strobe;
    strobe    = slow && !slow_prev;
    slow_prev = slow;
    m_valid   = 0;
    if (!en) begin
      m_pending = 0;
      e_cnt     = 0;
    end else begin
      if (strobe && m_pending) begin
        encode(m_pcm);
        m_valid   = 1;
        m_pending = 0;
      end
      hist[e_cnt] = pdm ? 1 : -1;
      if (e_cnt % 64 == 63) begin
        m_pcm     = pcm_at(e_cnt);
        m_pending = 1;
      end
      e_cnt++;
    end
  endtask

  task automatic cycle(input bit pdm, input bit slow, input bit en);
    @(negedge clk);
    pdm_in = pdm; slow_clk = slow; block_enable = en;
    model_step(pdm, slow, en);
    @(posedge clk);
    #1;
    check("outValid", outValid, m_valid);
    check("encPcm", encPcm, m_code);
    if (first_watch && outValid) begin
      check("first_code_all_ones", encPcm, 4'b0111);
      first_watch = 0;
    end
    cyc++;
  endtask

  // pmode: 0 alternating, 1 ones, 2 zeros, 3 random; smode: 0 clk/16, 1 held low, 2 random
  // emode: 0 enabled, 1 rare random disable, 2 disabled
  task automatic run(input int n, input int pmode, input int smode, input int emode);
    bit p, s, e;
    for (int i = 0; i < n; i++) begin
      case (pmode)
        0:       p = cyc[0];
        1:       p = 1;
        2:       p = 0;
        default: p = 1'($urandom % 2);
      endcase
      case (smode)
        0:       s = 1'((cyc >> 3) & 1);
        1:       s = 0;
        default: s = 1'($urandom % 2);
      endcase
      case (emode)
        0:       e = 1;
        1:       e = ($urandom_range(0, 199) != 0);
        default: e = 0;
      endcase
      cycle(p, s, e);
    end
  endtask

  initial begin
    int b2 [0:126];
    for (int k = 0; k < 127; k++) b2[k] = 0;
    for (int i = 0; i < 64; i++) for (int j = 0; j < 64; j++) b2[i + j]++;
    for (int k = 0; k < 190; k++) begin
      h[k] = 0;
      for (int j = 0; j < 64; j++) if (k - j >= 0 && k - j < 127) h[k] += b2[k - j];
    end
    cyc = 0; first_watch = 0;
    model_reset();

    #1;
    check("reset_outValid", outValid, 1'b0);
    check("reset_encPcm", encPcm, 4'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    first_watch = 1;
    run(1024, 1, 0, 0);
    run(100, 1, 0, 0);

    // asynchronous reset mid-decimation
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outValid", outValid, 1'b0);
    check("async_rst_encPcm", encPcm, 4'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    run(1024, 2, 0, 0);
    run(1024, 0, 0, 0);
    run(1024, 3, 0, 0);
    run(300, 3, 1, 0);
    run(200, 3, 0, 0);
    run(10, 3, 0, 2);
    run(512, 1, 0, 0);
    run(3000, 3, 2, 1);
    run(1000, 3, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
